// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. It covers the hazards that
//   bypassing cannot resolve: load-use, branch-in-decode dependence and the
//   multi-cycle occupancy of EX by mul/div operations. It also keeps a
//   saturating count of stall cycles for performance debug.
// Parameters
//   MD_LATENCY : cycles a mul/div op occupies EX (>= 2), giving MD_LATENCY-1 stall cycles
//   PERF_W     : width of the stall-cycle counter
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   RsD, RtD                : Decode source registers
//   RsE, RtE                : Execute source registers (not needed for stall decisions)
//   WriteRegE, WriteRegM    : destination registers in Execute / Memory
//   RegWriteE, MemtoRegE    : Execute writes the register file / is a load
//   MemtoRegM               : Memory instruction is a load
//   BranchD, PCSrcD         : Decode branch compares in Decode / branch taken
//   MulDivE                 : Execute holds a multi-cycle mul/div
//   StallF/D/E, FlushD/E/M  : pipeline register hold and clear enables
//   StallCount              : saturating count of cycles with StallF=1
module hazard_stall_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        RsE,
  input  logic [4:0]        RtE,
  input  logic [4:0]        WriteRegE,
  input  logic [4:0]        WriteRegM,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              PCSrcD,
  input  logic              MulDivE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [PERF_W-1:0] StallCount
);

  localparam int CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  // md_cnt holds the BUSY cycles still to come after the current one, so the
  // first stall cycle (in RUN) plus the BUSY cycles total MD_LATENCY-1.
  localparam logic [CNT_W-1:0] MD_LOAD  = CNT_W'((MD_LATENCY >= 3) ? (MD_LATENCY - 3) : 0);
  // With MD_LATENCY=2 the single stall cycle is the RUN cycle itself; no BUSY needed.
  localparam logic             SHORT_OP = (MD_LATENCY == 2) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {RUN = 1'b0, BUSY = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] md_cnt, md_cnt_nxt;
  logic             md_ack, md_ack_nxt;
  logic             lwstall, brstall, mdstall;

  // Execute source registers are only consumed by the bypass muxes.
  logic unused_bits;
  assign unused_bits = ^{RsE, RtE};

  // Hazard detection; register $0 never creates a dependence.
  always_comb begin
    lwstall = MemtoRegE && (WriteRegE != 5'd0) &&
              ((WriteRegE == RsD) || (WriteRegE == RtD));
    brstall = BranchD &&
              ((RegWriteE && (WriteRegE != 5'd0) &&
                ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
               (MemtoRegM && (WriteRegM != 5'd0) &&
                ((WriteRegM == RsD) || (WriteRegM == RtD))));
    mdstall = (state == BUSY) || ((state == RUN) && MulDivE && !md_ack);
  end

  // State register, mul/div counters and the saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      md_cnt     <= '0;
      md_ack     <= 1'b0;
      StallCount <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      md_ack <= md_ack_nxt;
      if (StallF && (StallCount != {PERF_W{1'b1}})) begin
        StallCount <= StallCount + PERF_W'(1);
      end else begin
        StallCount <= StallCount;
      end
    end
  end

  // Next-state logic for mul/div occupancy of EX.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    md_ack_nxt = md_ack;
    case (state)
      RUN: begin
        if (md_ack) begin
          // The finished op leaves EX this cycle; a MulDivE now is that op.
          md_ack_nxt = 1'b0;
        end else if (MulDivE) begin
          if (SHORT_OP) begin
            md_ack_nxt = 1'b1;
          end else begin
            state_nxt  = BUSY;
            md_cnt_nxt = MD_LOAD;
          end
        end else begin
          md_ack_nxt = 1'b0;
        end
      end
      BUSY: begin
        if (md_cnt != {CNT_W{1'b0}}) begin
          md_cnt_nxt = md_cnt - CNT_W'(1);
        end else begin
          state_nxt  = RUN;
          md_ack_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt  = RUN;
        md_cnt_nxt = '0;
        md_ack_nxt = 1'b0;
      end
    endcase
  end

  // Prioritised stall/flush outputs; everything is quiet during reset.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (rst) begin
      StallF = 1'b0;
    end else if (mdstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (lwstall || brstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      // A taken branch squashes IF/ID only when Decode is not held.
      FlushD = PCSrcD;
    end
  end

endmodule
